// File: rtl/cam_capture_ctrl_pkg.sv
// cam_capture_ctrl_pkg: capture FSM state encoding and default frame geometry.
package cam_capture_ctrl_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int ADDR_W_DEF   = 19;
  typedef enum logic [2:0] {IDLE, WAIT_VS_HIGH, WAIT_VS_LOW, CAPTURE, DONE} cap_state_t;
endpackage

// File: rtl/cam_pixel_pack.sv
// cam_pixel_pack: pairs RGB565 bytes (high first) into pixels and flags line ends.
module cam_pixel_pack (
  input  logic        pclk,
  input  logic        reset,
  input  logic        en,
  input  logic        href,
  input  logic [7:0]  data,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic        href_fall
);
  logic       phase, href_d;
  logic [7:0] hi;
  always_ff @(posedge pclk)
    if (reset) begin
      phase  <= 1'b0;
      href_d <= 1'b0;
      hi     <= '0;
    end else begin
      phase  <= en & href & ~phase;
      href_d <= en & href;
      if (en & href & ~phase) hi <= data;
    end
  assign pix_valid = en & href & phase;
  assign pix_data  = {hi, data};
  assign href_fall = en & href_d & ~href;
endmodule

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: camera frame capture FSM with framebuffer writer and host arbitration.
module cam_capture_ctrl
  import cam_capture_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              cap_start,
  input  logic              cap_continuous,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [15:0]       host_wdata,
  output logic              host_gnt,
  output logic              fb_wren,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [15:0]       fb_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              err_line_long
);
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0]     X_MAX  = XW'(H_ACTIVE);
  localparam logic [YW-1:0]     Y_MAX  = YW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);
  cap_state_t        state, state_n;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr, line_base;
  logic              capturing, pix_valid, href_fall, cam_wr;
  logic [15:0]       pix_data;
  assign capturing  = state == CAPTURE;
  assign busy       = state != IDLE;
  assign frame_done = state == DONE;
  cam_pixel_pack u_pack (
    .pclk      (pclk),
    .reset     (reset),
    .en        (capturing),
    .href      (cam_href),
    .data      (cam_data),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .href_fall (href_fall)
  );
  assign cam_wr   = pix_valid && x < X_MAX && y < Y_MAX;
  assign host_gnt = host_req & ~pix_valid & ~reset;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:         state_n = cap_start ? WAIT_VS_HIGH : IDLE;
      WAIT_VS_HIGH: state_n = cam_vsync ? WAIT_VS_LOW : WAIT_VS_HIGH;
      WAIT_VS_LOW:  state_n = cam_vsync ? WAIT_VS_LOW : CAPTURE;
      CAPTURE:      state_n = cam_vsync ? DONE : CAPTURE;
      DONE:         state_n = cap_continuous ? WAIT_VS_LOW : IDLE;
      default:      state_n = IDLE;
    endcase
  end
  always_ff @(posedge pclk)
    if (reset) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      addr          <= '0;
      line_base     <= '0;
      frame_count   <= '0;
      err_line_long <= 1'b0;
      fb_wren       <= 1'b0;
      fb_addr       <= '0;
      fb_wdata      <= '0;
    end else begin
      state   <= state_n;
      fb_wren <= cam_wr | host_gnt;
      if (cam_wr) begin
        fb_addr  <= addr;
        fb_wdata <= pix_data;
      end else if (host_gnt) begin
        fb_addr  <= host_addr;
        fb_wdata <= host_wdata;
      end
      if (state == DONE) frame_count <= frame_count + 8'd1;
      if (state == IDLE && cap_start) err_line_long <= 1'b0;
      else if (pix_valid && !(x < X_MAX)) err_line_long <= 1'b1;
      // Position counters only live inside CAPTURE, so every frame starts at the origin.
      if (!capturing) begin
        x         <= '0;
        y         <= '0;
        addr      <= '0;
        line_base <= '0;
      end else if (href_fall && x != '0) begin
        x         <= '0;
        y         <= (y < Y_MAX) ? y + YW'(1) : y;
        line_base <= line_base + H_STEP;
        addr      <= line_base + H_STEP;
      end else if (pix_valid && x < X_MAX) begin
        x <= x + XW'(1);
        if (cam_wr) addr <= addr + ADDR_W'(1);
      end
    end
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb_cam_capture_ctrl: directed checks of capture, line handling, arbitration and reset.
module tb_cam_capture_ctrl;
  localparam int H = 4, V = 2, AW = 19;
  logic          pclk = 1'b0, reset = 1'b1;
  logic          cam_vsync = 1'b0, cam_href = 1'b0, cap_start = 1'b0, cap_continuous = 1'b0;
  logic          host_req = 1'b0;
  logic [7:0]    cam_data = '0;
  logic [AW-1:0] host_addr = '0;
  logic [15:0]   host_wdata = '0;
  logic          host_gnt, fb_wren, busy, frame_done, err_line_long;
  logic [AW-1:0] fb_addr;
  logic [15:0]   fb_wdata;
  logic [7:0]    frame_count;
  int checks = 0, failures = 0, n_done = 0, w0, d0;
  logic [AW-1:0] wa[$];
  logic [15:0]   wd[$];

  cam_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .pclk(pclk), .reset(reset), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .cap_start(cap_start), .cap_continuous(cap_continuous),
    .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .fb_wren(fb_wren), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
    .err_line_long(err_line_long)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (fb_wren) begin
      wa.push_back(fb_addr);
      wd.push_back(fb_wdata);
    end
    if (frame_done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic start_frame();
    cam_vsync = 1'b1;
    cap_start = 1'b1;
    step();
    cap_start = 1'b0;
    step();
    step();
    cam_vsync = 1'b0;
    step();
    step();
  endtask

  task automatic end_frame();
    cam_vsync = 1'b1;
    step();
    step();
    step();
  endtask

  task automatic send_line(input int n, input logic [7:0] b0, input bit gchk);
    for (int i = 0; i < n; i++) begin
      cam_href = 1'b1;
      cam_data = b0 + 8'(i);
      host_req = gchk;
      #1;
      if (gchk) chk("host_gnt_burst", 32'(host_gnt), 32'((i % 2) == 0));
      step();
    end
    cam_href = 1'b0;
    host_req = 1'b0;
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    host_req = 1'b1;
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fb_wren", 32'(fb_wren), 0);
    chk("rst_fb_addr", 32'(fb_addr), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_err", 32'(err_line_long), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_host_gnt", 32'(host_gnt), 0);
    reset = 1'b0;
    host_req = 1'b0;
    step();

    w0 = wa.size();
    host_req = 1'b1;
    host_addr = 19'h123;
    host_wdata = 16'hbeef;
    #1;
    chk("idle_host_gnt", 32'(host_gnt), 1);
    step();
    host_req = 1'b0;
    step();
    chk("idle_host_writes", wa.size() - w0, 1);
    chk("idle_host_addr", 32'(wa[w0]), 32'h123);
    chk("idle_host_data", 32'(wd[w0]), 32'hbeef);
    chk("idle_wren_low", 32'(fb_wren), 0);

    w0 = wa.size();
    d0 = n_done;
    start_frame();
    chk("f1_busy", 32'(busy), 1);
    send_line(8, 8'h01, 1'b0);
    send_line(8, 8'h09, 1'b0);
    end_frame();
    chk("f1_writes", wa.size() - w0, 8);
    for (int k = 0; k < 8; k++) chk("f1_addr", 32'(wa[w0 + k]), k);
    chk("f1_first_data", 32'(wd[w0]), 32'h0102);
    chk("f1_last_data", 32'(wd[w0 + 7]), 32'h0f10);
    chk("f1_done_pulses", n_done - d0, 1);
    chk("f1_frame_count", 32'(frame_count), 1);
    chk("f1_busy_end", 32'(busy), 0);

    w0 = wa.size();
    start_frame();
    send_line(10, 8'h20, 1'b0);
    chk("long_err", 32'(err_line_long), 1);
    send_line(2, 8'h40, 1'b0);
    end_frame();
    chk("long_writes", wa.size() - w0, 5);
    chk("long_addr3", 32'(wa[w0 + 3]), 3);
    chk("long_data3", 32'(wd[w0 + 3]), 32'h2627);
    chk("long_next_addr", 32'(wa[w0 + 4]), 4);
    chk("long_next_data", 32'(wd[w0 + 4]), 32'h4041);
    chk("long_err_sticky", 32'(err_line_long), 1);

    w0 = wa.size();
    start_frame();
    chk("err_clr_on_start", 32'(err_line_long), 0);
    send_line(7, 8'h50, 1'b0);
    send_line(2, 8'h60, 1'b0);
    end_frame();
    chk("odd_writes", wa.size() - w0, 4);
    chk("odd_data2", 32'(wd[w0 + 2]), 32'h5455);
    chk("odd_next_addr", 32'(wa[w0 + 3]), 4);
    chk("odd_next_data", 32'(wd[w0 + 3]), 32'h6061);
    chk("odd_frame_count", 32'(frame_count), 3);

    host_addr = 19'h100;
    host_wdata = 16'hcafe;
    w0 = wa.size();
    start_frame();
    send_line(8, 8'h70, 1'b1);
    end_frame();
    chk("arb_writes", wa.size() - w0, 8);
    for (int k = 0; k < 8; k++) begin
      chk("arb_addr", 32'(wa[w0 + k]), (k % 2 == 0) ? 32'h100 : 32'(k / 2));
      chk("arb_data", 32'(wd[w0 + k]), (k % 2 == 0) ? 32'hcafe : 32'h7071 + 32'h0202 * 32'(k / 2));
    end

    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("cont_count_clr", 32'(frame_count), 0);
    d0 = n_done;
    cap_continuous = 1'b1;
    start_frame();
    for (int f = 0; f < 4; f++) begin
      if (f > 0) begin
        cam_vsync = 1'b0;
        step();
        step();
      end
      send_line(2, 8'h80, 1'b0);
      if (f == 3) cap_continuous = 1'b0;
      send_line(2, 8'h90, 1'b0);
      end_frame();
      chk("cont_busy", 32'(busy), 32'(f < 3));
    end
    chk("cont_done_pulses", n_done - d0, 4);
    chk("cont_frame_count", 32'(frame_count), 4);

    start_frame();
    w0 = wa.size();
    d0 = n_done;
    cam_href = 1'b1;
    cam_data = 8'h11;
    step();
    cam_data = 8'h22;
    reset = 1'b1;
    step();
    chk("rstmid_wren", 32'(fb_wren), 0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_count", 32'(frame_count), 0);
    chk("rstmid_done", 32'(frame_done), 0);
    reset = 1'b0;
    cam_data = 8'h33;
    step();
    cam_data = 8'h44;
    step();
    cam_href = 1'b0;
    cam_vsync = 1'b1;
    step();
    step();
    chk("rstmid_no_writes", wa.size() - w0, 0);
    chk("rstmid_no_done", n_done - d0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cam_capture_ctrl.md
CAM_CAPTURE_CTRL -- requirements
Module: cam_capture_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 Parameter ADDR_W, default 19, framebuffer word-address width.
REQ-004 Clock and reset SHALL be: reset reset, synchronous, active-high; clock pclk.
REQ-005 pclk  in  1  camera pixel clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 cam_vsync  in  1  camera frame sync; high between frames.
REQ-008 cam_href  in  1  camera line-valid; one byte per pclk while high.
REQ-009 cam_data  in  8  camera byte, RGB565, high byte first.
REQ-010 cap_start  in  1  one-cycle request to capture.
REQ-011 cap_continuous  in  1  1 = keep capturing frames; 0 = single frame.
REQ-012 host_req  in  1  host framebuffer write request.
REQ-013 host_addr  in  ADDR_W  host write address.
REQ-014 host_wdata  in  16  host write data.
REQ-015 host_gnt  out  1  host request accepted this cycle.
REQ-016 fb_wren  out  1  framebuffer write strobe.
REQ-017 fb_addr  out  ADDR_W  framebuffer write address.
REQ-018 fb_wdata  out  16  framebuffer write data.
REQ-019 busy  out  1  high in any state except IDLE.
REQ-020 frame_done  out  1  one-cycle pulse at end of a captured frame.
REQ-021 frame_count  out  8  completed frames, wraps 255->0.
REQ-022 err_line_long  out  1  sticky: a line exceeded H_ACTIVE pixels.

Function
REQ-023 FSM states SHALL be IDLE, WAIT_VS_HIGH, WAIT_VS_LOW, CAPTURE, DONE.
REQ-024 IDLE->WAIT_VS_HIGH on cap_start; cap_start in any other state SHALL be ignored.
REQ-025 WAIT_VS_HIGH->WAIT_VS_LOW when cam_vsync=1; WAIT_VS_LOW->CAPTURE when cam_vsync=0, with x, y, addr and byte phase cleared.
REQ-026 CAPTURE->DONE on cam_vsync=1; DONE lasts exactly one cycle, asserts frame_done and increments frame_count.
REQ-027 DONE->WAIT_VS_LOW if cap_continuous=1 at that cycle, else ->IDLE; clearing cap_continuous mid-frame SHALL finish the current frame.
REQ-028 Byte phase SHALL toggle on each CAPTURE cycle with cam_href=1 and clear whenever cam_href=0; phase 0 latches the high byte, phase 1 completes the pixel {hi,cam_data}.
REQ-029 A completed pixel SHALL be written only if x<H_ACTIVE and y<V_ACTIVE, at fb_addr=y*H_ACTIVE+x, produced from an incrementing running address (no multiplier).
REQ-030 Camera write SHALL appear on fb_wren/fb_addr/fb_wdata the cycle after the completing byte (1-cycle latency); x increments per completed pixel.
REQ-031 A completed pixel with x>=H_ACTIVE SHALL be dropped and SHALL set err_line_long.
REQ-032 Falling cam_href (1 then 0) with x>0 SHALL clear x and increment y; y SHALL saturate at V_ACTIVE.
REQ-033 Arbitration: camera has priority; host_gnt=host_req and no camera pixel completing this cycle (combinational).
REQ-034 A granted host write SHALL drive the fb port the next cycle with host_addr/host_wdata; host requests SHALL be granted in all states.
REQ-035 fb_wren SHALL be 0 in any cycle with neither a camera nor a granted host write.
REQ-036 An odd trailing byte at href fall SHALL be discarded.
REQ-037 err_line_long SHALL clear only on reset or an accepted cap_start.

Reset
REQ-038 Reset SHALL force IDLE, x=y=addr=0, phase=0, frame_count=0, err_line_long=0, and busy, frame_done, fb_wren, host_gnt, fb_addr, fb_wdata to 0.
REQ-039 Reset mid-CAPTURE SHALL abort the frame with no frame_done and no further writes.

Structure
REQ-040 Shared package SHALL hold the FSM state encoding and the H_ACTIVE/V_ACTIVE/ADDR_W defaults.
REQ-041 Sub-module cam_pixel_pack SHALL do byte pairing (phase, hi latch, pixel strobe); FSM, counters and arbiter SHALL stay in the top.

Verification (H_ACTIVE=4, V_ACTIVE=2)
REQ-042 cap_start, vsync 1->0, two lines of 8 bytes 0x01..0x10 -> 8 writes, addr 0..7, first data 0x0102, then vsync=1 -> one frame_done, frame_count=1, busy=0.
REQ-043 Line of 10 bytes -> 4 writes, err_line_long=1, next line starts at addr 4.
REQ-044 host_req held during pixel bursts -> host_gnt low on each pixel-completing cycle, high otherwise, no lost or duplicated write.
REQ-045 cap_continuous=1 for 3 frames then 0 mid-frame 4 -> frame_count=4, then IDLE.
REQ-046 reset asserted mid-line -> next cycle fb_wren=0, busy=0, frame_count=0, no frame_done.
REQ-047 7-byte line -> 3 writes, trailing byte dropped, y increments.
